// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity sense
// constants and the counter width helper used by rx and tx.
package uart_pkg;

    // PARITY only exists when parity is compiled in.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_t;

    localparam logic PARITY_EVEN  = 1'b0;
    localparam logic PARITY_ODD_C = 1'b1;

    // Width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Ports: in_clk, in_rst (async, active-high), in_d, out_q.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic in_clk,
    input  logic in_rst,
    input  logic in_d,
    output logic out_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= in_d;
            r_sync <= r_meta;
        end
    end

    assign out_q = r_sync;

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver with configurable data/stop bits, glitch-
// rejecting start detect and a valid/ready word output with error flags.
// Optional parity is compiled in with the UART_RX_PARITY_EN macro.
// Ports: in_clk, in_rst (async, active-high), rx_serial (idle high),
//   out_data/out_valid/in_ready word handshake, out_parity_err,
//   out_frame_err, out_overrun (1-cycle drop pulse), out_busy.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int   CLKS_PER_BIT = 87,
    parameter int   DATA_BITS    = 8,
    parameter int   STOP_BITS    = 1,
    parameter logic PARITY_ODD   = 1'b0
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 in_ready,
    output logic                 out_parity_err,
    output logic                 out_frame_err,
    output logic                 out_overrun,
    output logic                 out_busy
);

    localparam int CW = cnt_w(CLKS_PER_BIT);
    localparam int BW = cnt_w(DATA_BITS + 1);

    // Counters run down to zero, so loads are "period - 1".
    localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    logic                 w_rx;
    logic                 w_tick;
    logic                 w_ferr_fin;
    logic                 r_prev;
    rx_state_t            r_state;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bits;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_ferr;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr_o;
    logic                 r_overrun;
`ifdef UART_RX_PARITY_EN
    logic                 r_perr;
    logic                 r_perr_o;
`endif

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .in_clk (in_clk),
        .in_rst (in_rst),
        .in_d   (rx_serial),
        .out_q  (w_rx)
    );

    assign w_tick     = (r_cnt == '0);
    assign w_ferr_fin = r_ferr | ~w_rx;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_prev    <= 1'b1;
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bits    <= '0;
            r_shift   <= '0;
            r_ferr    <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr_o  <= 1'b0;
            r_overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr    <= 1'b0;
            r_perr_o  <= 1'b0;
`endif
        end else begin
            r_prev    <= w_rx;
            r_overrun <= 1'b0;
            if (r_valid && in_ready)
                r_valid <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (r_prev && !w_rx) begin
                        r_cnt   <= HALF_M1;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else if (!w_rx) begin
                        r_cnt   <= FULL_M1;
                        r_bits  <= '0;
                        r_ferr  <= 1'b0;
                        r_state <= ST_DATA;
                    end else begin
                        // Line back high at mid-start: glitch.
                        r_state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_cnt   <= FULL_M1;
                        r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
                        if (r_bits == LAST_DATA) begin
                            r_bits  <= '0;
`ifdef UART_RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_bits <= r_bits + BW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_cnt   <= FULL_M1;
                        r_perr  <= ^r_shift ^ w_rx
                                 ^ (PARITY_ODD == PARITY_ODD_C);
                        r_state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else if (r_bits != LAST_STOP) begin
                        r_cnt  <= FULL_M1;
                        r_bits <= r_bits + BW'(1);
                        r_ferr <= w_ferr_fin;
                    end else begin
                        r_bits  <= '0;
                        r_state <= w_rx ? ST_IDLE : ST_WAIT_IDLE;
                        // Load only if the holding register frees up.
                        if (!r_valid || in_ready) begin
                            r_data   <= r_shift;
                            r_ferr_o <= w_ferr_fin;
                            r_valid  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            r_perr_o <= r_perr;
`endif
                        end else begin
                            r_overrun <= 1'b1;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    // A held-low line (break) must not look like a start.
                    if (w_rx)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_data      = r_data;
    assign out_valid     = r_valid;
    assign out_frame_err = r_ferr_o;
    assign out_overrun   = r_overrun;
    assign out_busy      = (r_state != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign out_parity_err = r_perr_o;
`else
    assign out_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at 87 clocks/bit, 8 data, 1 stop.
// Parity cases are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx_frame;

    localparam int CLKS = 87;
    localparam int DB   = 8;
    localparam int SB   = 1;
`ifdef UART_RX_PARITY_EN
    localparam int PB   = 1;
`else
    localparam int PB   = 0;
`endif
    // Cycle at which out_valid is first seen, counted from cycle 0.
    localparam int T_VALID = 2 + CLKS / 2 + CLKS * (DB + PB + SB) + 1;

    logic          clk;
    logic          rst;
    logic          rx;
    logic          ready;
    logic [DB-1:0] data;
    logic          valid;
    logic          perr;
    logic          ferr;
    logic          ovr;
    logic          busy;

    uart_rx_frame #(
        .CLKS_PER_BIT (CLKS),
        .DATA_BITS    (DB),
        .STOP_BITS    (SB),
        .PARITY_ODD   (1'b0)
    ) dut (
        .in_clk         (clk),
        .in_rst         (rst),
        .rx_serial      (rx),
        .out_data       (data),
        .out_valid      (valid),
        .in_ready       (ready),
        .out_parity_err (perr),
        .out_frame_err  (ferr),
        .out_overrun    (ovr),
        .out_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         c;
    } cap_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic [7:0] exp_d;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    cap_t q[$];
    int   cyc;
    int   ovr_cnt;
    int   t0;
    int   checks;
    int   fails;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid && ready)
                q.push_back('{data, perr, ferr, cyc});
            if (ovr)
                ovr_cnt = ovr_cnt + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input int n);
        rx = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p);
        @(posedge clk);
        #1;
        t0 = cyc + 1;
        drive_bit(1'b0, CLKS);
        for (int i = 0; i < DB; i++)
            drive_bit(d[i], CLKS);
`ifdef UART_RX_PARITY_EN
        drive_bit(p, CLKS);
`endif
        for (int i = 0; i < SB; i++)
            drive_bit(1'b1, CLKS);
    endtask

    vec_t vt[6];

    initial begin
        cyc     = 0;
        ovr_cnt = 0;
        checks  = 0;
        fails   = 0;
        t0      = 0;
        rst     = 1'b1;
        rx      = 1'b1;
        ready   = 1'b1;

        // Even parity bit = XOR of the data bits.
        vt[0] = '{8'h3F, 1'b0, 8'h3F, 1'b0, 1'b0};
        vt[1] = '{8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0};
        vt[2] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[3] = '{8'h80, 1'b1, 8'h80, 1'b0, 1'b0};
        vt[4] = '{8'h01, 1'b1, 8'h01, 1'b0, 1'b0};
        vt[5] = '{8'h5A, 1'b0, 8'h5A, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", int'(data), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_perr", int'(perr), 0);
        chk("rst_ferr", int'(ferr), 0);
        chk("rst_ovr", int'(ovr), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // Back-to-back table frames, consumer always ready.
        q.delete();
        for (int i = 0; i < 6; i++) begin
            send_frame(vt[i].data, vt[i].par);
            if (i == 0) begin
                repeat (3) @(posedge clk);
                chk("first_valid_cycle", q.size() > 0 ?
                    q[0].c - t0 + 1 : -1, T_VALID);
            end
        end
        repeat (2 * CLKS) @(posedge clk);
        chk("table_count", q.size(), 6);
        for (int i = 0; i < 6 && i < q.size(); i++) begin
            chk($sformatf("vec%0d_data", i), int'(q[i].d),
                int'(vt[i].exp_d));
            chk($sformatf("vec%0d_perr", i), int'(q[i].pe),
                int'(vt[i].exp_pe));
            chk($sformatf("vec%0d_ferr", i), int'(q[i].fe),
                int'(vt[i].exp_fe));
        end

        // Start glitch: 20 low cycles.
        q.delete();
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("glitch_busy_hi", int'(busy), 1);
        rx = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        chk("glitch_busy_lo", int'(busy), 0);
        repeat (200) @(posedge clk);
        chk("glitch_no_word", q.size(), 0);

`ifdef UART_RX_PARITY_EN
        // 0xA5 has four ones: even parity expects 0.
        q.delete();
        send_frame(8'hA5, 1'b1);
        send_frame(8'hA5, 1'b0);
        repeat (2 * CLKS) @(posedge clk);
        chk("par_count", q.size(), 2);
        if (q.size() == 2) begin
            chk("par_bad_data", int'(q[0].d), 8'hA5);
            chk("par_bad_err", int'(q[0].pe), 1);
            chk("par_ok_err", int'(q[1].pe), 0);
        end
`endif

        // Low stop bit followed by a 2-bit-period break.
        q.delete();
        @(posedge clk);
        #1;
        drive_bit(1'b0, CLKS);
        for (int i = 0; i < DB; i++)
            drive_bit(i[0] ? 1'b0 : 1'b1, CLKS);
`ifdef UART_RX_PARITY_EN
        drive_bit(1'b0, CLKS);
`endif
        drive_bit(1'b0, 130);
        chk("break_busy", int'(busy), 1);
        drive_bit(1'b0, 2 * CLKS - 130);
        drive_bit(1'b1, CLKS);
        send_frame(8'h01, 1'b1);
        repeat (2 * CLKS) @(posedge clk);
        chk("ferr_count", q.size(), 2);
        if (q.size() == 2) begin
            chk("ferr_data", int'(q[0].d), 8'h55);
            chk("ferr_flag", int'(q[0].fe), 1);
            chk("after_data", int'(q[1].d), 8'h01);
            chk("after_ferr", int'(q[1].fe), 0);
        end

        // Overrun: consumer stalled across two words.
        q.delete();
        ovr_cnt = 0;
        ready   = 1'b0;
        send_frame(8'h11, 1'b0);
        send_frame(8'h22, 1'b0);
        repeat (2 * CLKS) @(posedge clk);
        #1;
        chk("ovr_valid", int'(valid), 1);
        chk("ovr_held", int'(data), 8'h11);
        chk("ovr_pulses", ovr_cnt, 1);
        ready = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        chk("ovr_count", q.size(), 1);
        if (q.size() == 1)
            chk("ovr_word", int'(q[0].d), 8'h11);
        chk("ovr_drained", int'(valid), 0);

        // Reset mid-frame during data bit 4 of 0x3C.
        q.delete();
        @(posedge clk);
        #1;
        drive_bit(1'b0, CLKS);
        for (int i = 0; i < 4; i++)
            drive_bit(i >= 2 ? 1'b1 : 1'b0, CLKS);
        drive_bit(1'b1, 40);
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        drive_bit(1'b1, CLKS - 40);
        drive_bit(1'b1, 2 * CLKS);
        drive_bit(1'b0, 2 * CLKS);
        drive_bit(1'b1, CLKS);
        rst = 1'b0;
        repeat (2 * CLKS) @(posedge clk);
        chk("abort_no_word", q.size(), 0);
        send_frame(8'h3C, 1'b0);
        repeat (2 * CLKS) @(posedge clk);
        chk("resend_count", q.size(), 1);
        if (q.size() == 1)
            chk("resend_data", int'(q[0].d), 8'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
